// File: rtl/nec_ir_transmitter.sv
// NEC IR transmitter: serialises a latched 32-bit code into a 38 kHz modulated
// mark/space frame, then emits repeat frames every FRAME_UNITS units while hold is high.
module nec_ir_transmitter #(
  parameter int UNIT_CYCLES = 56250,
  parameter int CARR_PERIOD = 2632,
  parameter int CARR_HIGH   = 877,
  parameter int FRAME_UNITS = 192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] code,
  input  logic        send,
  input  logic        hold,
  output logic        busy,
  output logic        done,
  output logic        env_o,
  output logic        ir_o
);

  localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int CW = (CARR_PERIOD > 1) ? $clog2(CARR_PERIOD) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_REP_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_STOP_MARK,
    S_GAP
  } state_t;

  state_t      state, state_d;
  logic [UW-1:0] unit_cnt, unit_cnt_d;
  logic [CW-1:0] carr_cnt, carr_cnt_d;
  logic [4:0]  state_units, state_units_d;
  logic [7:0]  frame_units, frame_units_d, frame_units_ticked;
  logic [4:0]  bit_idx, bit_idx_d;
  logic [31:0] code_q, code_d;
  logic        rep_q, rep_d;
  logic        unit_tick, seg_end, cur_bit, state_change;
  logic [4:0]  state_len;
  logic        env_d, ir_d, done_d, busy_d;

  function automatic logic is_mark(input state_t s);
    return (s == S_LEAD_MARK) || (s == S_BIT_MARK) || (s == S_STOP_MARK);
  endfunction

  always_comb begin
    unit_tick = (unit_cnt == UW'(UNIT_CYCLES - 1));
    cur_bit   = code_q[5'd31 - bit_idx];

    case (state)
      S_LEAD_MARK:  state_len = 5'd16;
      S_LEAD_SPACE: state_len = 5'd8;
      S_REP_SPACE:  state_len = 5'd4;
      S_BIT_SPACE:  state_len = cur_bit ? 5'd3 : 5'd1;
      default:      state_len = 5'd1;
    endcase
    seg_end = unit_tick && (state_units == state_len - 5'd1);

    if (unit_tick && (frame_units != 8'(FRAME_UNITS)))
      frame_units_ticked = frame_units + 8'd1;
    else
      frame_units_ticked = frame_units;

    state_d       = state;
    bit_idx_d     = bit_idx;
    code_d        = code_q;
    rep_d         = rep_q;
    frame_units_d = frame_units_ticked;

    case (state)
      S_IDLE: begin
        frame_units_d = frame_units;
        if (send) begin
          code_d        = code;
          bit_idx_d     = '0;
          frame_units_d = '0;
          rep_d         = 1'b0;
          state_d       = S_LEAD_MARK;
        end
      end
      S_LEAD_MARK:  if (seg_end) state_d = rep_q ? S_REP_SPACE : S_LEAD_SPACE;
      S_LEAD_SPACE: if (seg_end) state_d = S_BIT_MARK;
      S_REP_SPACE:  if (seg_end) state_d = S_STOP_MARK;
      S_BIT_MARK:   if (seg_end) state_d = S_BIT_SPACE;
      S_BIT_SPACE: begin
        if (seg_end) begin
          if (bit_idx == 5'd31) begin
            state_d = S_STOP_MARK;
          end else begin
            bit_idx_d = bit_idx + 5'd1;
            state_d   = S_BIT_MARK;
          end
        end
      end
      S_STOP_MARK:  if (seg_end) state_d = S_GAP;
      S_GAP: begin
        if (frame_units_ticked == 8'(FRAME_UNITS)) begin
          if (hold) begin
            state_d       = S_LEAD_MARK;
            rep_d         = 1'b1;
            frame_units_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    state_change = (state_d != state);

    if (state_change || unit_tick || (state == S_IDLE))
      unit_cnt_d = '0;
    else
      unit_cnt_d = unit_cnt + UW'(1);

    if (state_change)
      state_units_d = '0;
    else if (unit_tick)
      state_units_d = state_units + 5'd1;
    else
      state_units_d = state_units;

    if ((state_change && is_mark(state_d)) || (carr_cnt == CW'(CARR_PERIOD - 1)))
      carr_cnt_d = '0;
    else
      carr_cnt_d = carr_cnt + CW'(1);

    // Outputs are decoded from next-state values so the registered pins line
    // up with the state they describe, with no extra cycle of latency.
    env_d  = is_mark(state_d);
    ir_d   = env_d && (carr_cnt_d < CW'(CARR_HIGH));
    done_d = (state_d == S_STOP_MARK) && (unit_cnt_d == UW'(UNIT_CYCLES - 1))
             && (state_units_d == 5'd0);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      unit_cnt    <= '0;
      carr_cnt    <= '0;
      state_units <= '0;
      frame_units <= '0;
      bit_idx     <= '0;
      code_q      <= '0;
      rep_q       <= 1'b0;
      env_o       <= 1'b0;
      ir_o        <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      unit_cnt    <= unit_cnt_d;
      carr_cnt    <= carr_cnt_d;
      state_units <= state_units_d;
      frame_units <= frame_units_d;
      bit_idx     <= bit_idx_d;
      code_q      <= code_d;
      rep_q       <= rep_d;
      env_o       <= env_d;
      ir_o        <= ir_d;
      done        <= done_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_nec_ir_transmitter.sv
// Directed bench for nec_ir_transmitter with shortened timing (4-cycle unit,
// 3-cycle carrier, 1 high cycle); expected waveforms are built from frame segment lengths.
module tb_nec_ir_transmitter;

  logic        clk = 1'b0;
  logic        rst, send, hold;
  logic [31:0] code;
  logic        busy, done, env_o, ir_o;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] CODE_A = 32'h00FF40BF;
  localparam logic [31:0] CODE_B = 32'hA5A55AA5;

  logic env_w [0:2499];
  logic ir_w  [0:2499];
  logic done_w[0:2499];
  logic busy_w[0:2499];
  logic exp_env[0:2499];
  logic exp_ir [0:2499];
  int   pos;

  nec_ir_transmitter #(
    .UNIT_CYCLES(4),
    .CARR_PERIOD(3),
    .CARR_HIGH(1),
    .FRAME_UNITS(192)
  ) dut (
    .clk(clk), .rst(rst), .code(code), .send(send), .hold(hold),
    .busy(busy), .done(done), .env_o(env_o), .ir_o(ir_o)
  );

  always #5 clk = ~clk;

  // Carrier pattern inside a mark is 1,0,0 starting at the mark's first cycle.
  task automatic seg(input int len, input logic mark);
    for (int i = 0; i < len; i++) begin
      exp_env[pos + i] = mark;
      exp_ir[pos + i]  = mark && ((i % 3) == 0);
    end
    pos += len;
  endtask

  task automatic build_full(input logic [31:0] c, input int base);
    pos = base;
    seg(64, 1'b1);
    seg(32, 1'b0);
    for (int b = 31; b >= 0; b--) begin
      seg(4, 1'b1);
      seg(c[b] ? 12 : 4, 1'b0);
    end
    seg(4, 1'b1);
    seg(768 - 484, 1'b0);
  endtask

  task automatic build_rep(input int base);
    pos = base;
    seg(64, 1'b1);
    seg(16, 1'b0);
    seg(4, 1'b1);
    seg(768 - 84, 1'b0);
  endtask

  function automatic int wave_errs(input int lo, input int hi);
    int e = 0;
    for (int k = lo; k <= hi; k++)
      if (env_w[k] !== exp_env[k] || ir_w[k] !== exp_ir[k]) e++;
    return e;
  endfunction

  function automatic int done_count(input int lo, input int hi);
    int e = 0;
    for (int k = lo; k <= hi; k++)
      if (done_w[k] === 1'b1) e++;
    return e;
  endfunction

  function automatic int busy_lows(input int lo, input int hi);
    int e = 0;
    for (int k = lo; k <= hi; k++)
      if (busy_w[k] !== 1'b1) e++;
    return e;
  endfunction

  // Leaves the bench at the sampling point of cycle 1 (first cycle after acceptance).
  task automatic start_frame(input logic [31:0] c, input logic h);
    @(negedge clk);
    code = c;
    hold = h;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
  endtask

  task automatic capture(input int n, input int drop_at, input bit disturb);
    for (int k = 1; k <= n; k++) begin
      env_w[k]  = env_o;
      ir_w[k]   = ir_o;
      done_w[k] = done;
      busy_w[k] = busy;
      if (k == drop_at) hold = 1'b0;
      if (disturb) begin
        code = $urandom;
        send = (k < 700) && ((k % 5) == 0);
      end
      @(negedge clk);
    end
    send = 1'b0;
  endtask

  task automatic test_reset;
    int highs;
    rst = 1'b1; send = 1'b0; hold = 1'b0; code = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (env_o !== 1'b0) begin n_fail++; $display("FAIL reset_env: got %b expected 0", env_o); end
    n_checks++; if (ir_o !== 1'b0)  begin n_fail++; $display("FAIL reset_ir: got %b expected 0", ir_o); end
    code = CODE_A;
    send = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || env_o !== 1'b0) begin
      n_fail++; $display("FAIL send_under_rst: busy=%b env=%b expected 0 0", busy, env_o);
    end
    rst = 1'b0; send = 1'b0;
    highs = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || env_o !== 1'b0 || done !== 1'b0) highs++;
    end
    n_checks++; if (highs !== 0) begin n_fail++; $display("FAIL idle_after_rst: got %0d active cycles expected 0", highs); end
  endtask

  task automatic test_full_frame;
    build_full(CODE_A, 1);
    start_frame(CODE_A, 1'b0);
    capture(800, 0, 1'b0);
    n_checks++; if (env_w[1] !== 1'b1 || ir_w[1] !== 1'b1) begin
      n_fail++; $display("FAIL first_mark_cycle: env=%b ir=%b expected 1 1", env_w[1], ir_w[1]);
    end
    n_checks++; if (wave_errs(1, 768) !== 0) begin
      n_fail++; $display("FAIL full_wave: got %0d bad cycles expected 0", wave_errs(1, 768));
    end
    n_checks++; if (env_w[484] !== 1'b1 || env_w[485] !== 1'b0) begin
      n_fail++; $display("FAIL stop_mark_end: env[484]=%b env[485]=%b expected 1 0", env_w[484], env_w[485]);
    end
    n_checks++; if (done_count(1, 800) !== 1) begin
      n_fail++; $display("FAIL full_done_count: got %0d expected 1", done_count(1, 800));
    end
    n_checks++; if (done_w[484] !== 1'b1) begin n_fail++; $display("FAIL full_done_cycle: done[484]=%b expected 1", done_w[484]); end
    n_checks++; if (busy_lows(1, 768) !== 0) begin
      n_fail++; $display("FAIL full_busy_high: got %0d low cycles expected 0", busy_lows(1, 768));
    end
    n_checks++; if (busy_w[769] !== 1'b0) begin n_fail++; $display("FAIL full_busy_fall: busy[769]=%b expected 0", busy_w[769]); end
  endtask

  task automatic test_hold_repeat;
    build_full(CODE_A, 1);
    build_rep(769);
    build_rep(1537);
    seg(2400 - 2304, 1'b0);
    start_frame(CODE_A, 1'b1);
    capture(2400, 1600, 1'b0);
    n_checks++; if (wave_errs(1, 2400) !== 0) begin
      n_fail++; $display("FAIL repeat_wave: got %0d bad cycles expected 0", wave_errs(1, 2400));
    end
    n_checks++; if (ir_w[769] !== 1'b1 || ir_w[770] !== 1'b0 || ir_w[772] !== 1'b1 || ir_w[849] !== 1'b1) begin
      n_fail++; $display("FAIL repeat_carrier: ir769=%b ir770=%b ir772=%b ir849=%b expected 1 0 1 1",
                         ir_w[769], ir_w[770], ir_w[772], ir_w[849]);
    end
    n_checks++; if (done_count(1, 2400) !== 3) begin
      n_fail++; $display("FAIL repeat_done_count: got %0d expected 3", done_count(1, 2400));
    end
    n_checks++; if (done_w[852] !== 1'b1 || done_w[1620] !== 1'b1) begin
      n_fail++; $display("FAIL repeat_done_cycle: done852=%b done1620=%b expected 1 1", done_w[852], done_w[1620]);
    end
    n_checks++; if (busy_lows(1, 2304) !== 0) begin
      n_fail++; $display("FAIL repeat_busy_high: got %0d low cycles expected 0", busy_lows(1, 2304));
    end
    n_checks++; if (busy_w[2305] !== 1'b0 || busy_w[2400] !== 1'b0) begin
      n_fail++; $display("FAIL repeat_busy_fall: busy2305=%b busy2400=%b expected 0 0", busy_w[2305], busy_w[2400]);
    end
  endtask

  task automatic test_busy_ignore;
    build_full(CODE_A, 1);
    start_frame(CODE_A, 1'b0);
    capture(800, 0, 1'b1);
    code = CODE_A;
    n_checks++; if (wave_errs(1, 768) !== 0) begin
      n_fail++; $display("FAIL ignore_wave: got %0d bad cycles expected 0", wave_errs(1, 768));
    end
    n_checks++; if (done_count(1, 800) !== 1) begin
      n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", done_count(1, 800));
    end
    n_checks++; if (busy_w[769] !== 1'b0 || busy_w[800] !== 1'b0) begin
      n_fail++; $display("FAIL ignore_busy_fall: busy769=%b busy800=%b expected 0 0", busy_w[769], busy_w[800]);
    end
  endtask

  task automatic test_reset_mid;
    int bad;
    start_frame(CODE_A, 1'b0);
    capture(194, 0, 1'b0);
    n_checks++; if (env_w[193] !== 1'b1 || ir_w[193] !== 1'b1) begin
      n_fail++; $display("FAIL bit10_mark: env=%b ir=%b expected 1 1", env_w[193], ir_w[193]);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (env_o !== 1'b0 || ir_o !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_outputs: env=%b ir=%b busy=%b done=%b expected 0 0 0 0", env_o, ir_o, busy, done);
    end
    rst = 1'b0;
    bad = 0;
    repeat (600) begin
      @(negedge clk);
      if (env_o !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL abort_quiet: got %0d active cycles expected 0", bad); end
    build_full(CODE_B, 1);
    start_frame(CODE_B, 1'b0);
    capture(800, 0, 1'b0);
    n_checks++; if (wave_errs(1, 768) !== 0) begin
      n_fail++; $display("FAIL fresh_wave: got %0d bad cycles expected 0", wave_errs(1, 768));
    end
    n_checks++; if (done_w[484] !== 1'b1 || done_count(1, 800) !== 1) begin
      n_fail++; $display("FAIL fresh_done: done484=%b count=%0d expected 1 1", done_w[484], done_count(1, 800));
    end
    n_checks++; if (busy_w[769] !== 1'b0) begin n_fail++; $display("FAIL fresh_busy_fall: busy769=%b expected 0", busy_w[769]); end
  endtask

  initial begin
    test_reset;
    test_full_frame;
    test_hold_repeat;
    test_busy_ignore;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
